// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared encodings for the nibble-serial adder controller and its 4-bit slice.
// Holds ALU control codes, FSM state codes, op codes and the overflow helper.
package nibble_serial_adder_ctrl_pkg;

    typedef logic [2:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_AND = 3'b000;
    localparam alu_ctrl_t ALU_OR  = 3'b001;
    localparam alu_ctrl_t ALU_ADD = 3'b010;
    localparam alu_ctrl_t ALU_SUB = 3'b110;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Signed overflow: operands agree in sign but the result sign differs.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Issue/result bundle between an issuing unit (master) and the serial adder (slave).
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// Four-bit ripple-carry ALU slice (AND/OR/ADD/SUB); the controller uses it as a plain adder.
module nibble_serial_adder_ctrl_slice
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    input  alu_ctrl_t  i_ctrl,
    output logic [3:0] o_y,
    output logic       o_cout
);

    logic [3:0] w_b_in;
    logic       w_cin;
    logic [4:1] w_c;
    logic [3:0] w_sum;

    // Operand conditioning: SUB inverts B and forces the carry-in.
    always_comb begin
        if (i_ctrl == ALU_SUB) begin
            w_b_in = ~i_b;
            w_cin  = 1'b1;
        end else begin
            w_b_in = i_b;
            w_cin  = i_cin;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_fa
            logic w_ci;
            if (g == 0) begin : g_first
                assign w_ci = w_cin;
            end else begin : g_rest
                assign w_ci = w_c[g];
            end
            assign w_sum[g]  = i_a[g] ^ w_b_in[g] ^ w_ci;
            assign w_c[g+1]  = (i_a[g] & w_b_in[g]) | (w_ci & (i_a[g] ^ w_b_in[g]));
        end
    endgenerate

    // Function select for the slice output.
    always_comb begin
        o_y    = 4'h0;
        o_cout = 1'b0;
        case (i_ctrl)
            ALU_AND: begin
                o_y    = i_a & i_b;
                o_cout = 1'b0;
            end
            ALU_OR: begin
                o_y    = i_a | i_b;
                o_cout = 1'b0;
            end
            ALU_ADD, ALU_SUB: begin
                o_y    = w_sum;
                o_cout = w_c[4];
            end
            default: begin
                o_y    = 4'h0;
                o_cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract done serially through one 4-bit slice, LS nibble first.
// Carry is held in a register between nibbles; flags are captured with the last nibble.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nibble_serial_adder_ctrl_if.slave bus
);

    localparam int NIBS  = WIDTH / 4;
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBS - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a_lat;
    logic [WIDTH-1:0] r_b_eff;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_overflow;
    logic             r_zero;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_result_next;
    logic             w_last;

    // Select the current nibble and splice the slice output into the result.
    always_comb begin
        w_a_nib       = r_a_lat[{r_idx, 2'b00} +: 4];
        w_b_nib       = r_b_eff[{r_idx, 2'b00} +: 4];
        w_result_next = r_result;
        w_result_next[{r_idx, 2'b00} +: 4] = w_sum;
        w_last        = (r_idx == IDX_LAST);
    end

    nibble_serial_adder_ctrl_slice u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .i_ctrl (ALU_ADD),
        .o_y    (w_sum),
        .o_cout (w_cout)
    );

    // Control FSM with operand, carry, result and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= {IDX_W{1'b0}};
            r_a_lat    <= {WIDTH{1'b0}};
            r_b_eff    <= {WIDTH{1'b0}};
            r_carry    <= 1'b0;
            r_result   <= {WIDTH{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_lat <= bus.a;
                        r_b_eff <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        r_carry <= bus.op;
                        r_idx   <= {IDX_W{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_done   <= 1'b0;
                    r_result <= w_result_next;
                    r_carry  <= w_cout;
                    r_idx    <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        // Flags see the fully assembled result, including this nibble.
                        r_busy     <= 1'b0;
                        r_cout     <= w_cout;
                        r_overflow <= add_overflow(r_a_lat[WIDTH-1], r_b_eff[WIDTH-1],
                                                   w_result_next[WIDTH-1]);
                        r_zero     <= (w_result_next == {WIDTH{1'b0}});
                        r_state    <= ST_DONE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_overflow;
    assign bus.zero     = r_zero;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16) with hand-computed expectations.
module tb_nibble_serial_adder_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   busy_cnt;
    int   lat;
    int   lat2;
    int   done_seen;

    nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns just after the accepting edge (edge + 1ns).
    task automatic start_op(input logic op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges until done is seen; counts busy samples on the way. Bounded.
    task automatic wait_done(output int edges);
        int got;
        got      = 0;
        edges    = 0;
        busy_cnt = 0;
        while (got == 0 && edges < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            edges++;
            if (bus.done === 1'b1) got = 1;
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] r, input logic c,
                             input logic v, input logic z);
        check({tag, "_result"}, 32'(bus.result), 32'(r));
        check({tag, "_cout"}, 32'(bus.cout), 32'(c));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(v));
        check({tag, "_zero"}, 32'(bus.zero), 32'(z));
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        n_checks  = 0;
        n_errors  = 0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD 0x1234 + 0x4321
        start_op(1'b0, 16'h1234, 16'h4321);
        wait_done(lat);
        check("add1_latency", 32'(lat), 32'd5);
        check("add1_busy_cycles", 32'(busy_cnt), 32'd4);
        check_res("add1", 16'h5555, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("add1_done_pulse", 32'(bus.done), 32'd0);
        check("add1_hold", 32'(bus.result), 32'h5555);

        // ADD 0xFFFF + 0x0001: carry through all nibbles
        start_op(1'b0, 16'hFFFF, 16'h0001);
        wait_done(lat);
        check("add2_latency", 32'(lat), 32'd5);
        check_res("add2", 16'h0000, 1'b1, 1'b0, 1'b1);

        // ADD 0x7FFF + 0x0001: positive overflow
        start_op(1'b0, 16'h7FFF, 16'h0001);
        wait_done(lat);
        check("add3_latency", 32'(lat), 32'd5);
        check_res("add3", 16'h8000, 1'b0, 1'b1, 1'b0);

        // SUB 0x8000 - 0x0001: negative overflow, no borrow
        start_op(1'b1, 16'h8000, 16'h0001);
        wait_done(lat);
        check("sub1_latency", 32'(lat), 32'd5);
        check_res("sub1", 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // SUB 0x0005 - 0x0007: borrow
        start_op(1'b1, 16'h0005, 16'h0007);
        wait_done(lat);
        check("sub2_latency", 32'(lat), 32'd5);
        check_res("sub2", 16'hFFFE, 1'b0, 1'b0, 1'b0);

        // SUB 0x0007 - 0x0007: zero
        start_op(1'b1, 16'h0007, 16'h0007);
        wait_done(lat);
        check("sub3_latency", 32'(lat), 32'd5);
        check_res("sub3", 16'h0000, 1'b1, 1'b0, 1'b1);

        // Reset during the second RUN nibble clears everything at once
        start_op(1'b0, 16'h1234, 16'h1111);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check_res("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_seen++;
        end
        check("mid_rst_no_done", 32'(done_seen), 32'd0);
        start_op(1'b0, 16'h0010, 16'h0020);
        wait_done(lat);
        check("post_rst_latency", 32'(lat), 32'd5);
        check_res("post_rst", 16'h0030, 1'b0, 1'b0, 1'b0);

        // start with new operands during RUN and DONE is ignored
        start_op(1'b0, 16'h1111, 16'h2222);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0F0F;
        wait_done(lat);
        bus.start = 1'b0;
        check("ign_latency", 32'(lat), 32'd5);
        check_res("ign", 16'h3333, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("ign_not_queued", 32'(bus.busy), 32'd0);
        check("ign_hold", 32'(bus.result), 32'h3333);

        // start held high: back-to-back every 6 cycles, operands changed after acceptance
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 16'h0001;
        bus.b     = 16'h0002;
        @(posedge clk);
        #1;
        bus.a = 16'h0010;
        bus.b = 16'h0020;
        wait_done(lat);
        check("b2b_first_latency", 32'(lat), 32'd5);
        check("b2b_first_result", 32'(bus.result), 32'h0003);
        wait_done(lat2);
        bus.start = 1'b0;
        check("b2b_interval", 32'(lat2), 32'd6);
        check("b2b_busy_cycles", 32'(busy_cnt), 32'd4);
        check("b2b_second_result", 32'(bus.result), 32'h0030);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
